// File: rtl/vc_time_buffer.sv
// vc_time_buffer: five independent timestamp FIFOs, one per virtual channel.
// Each VC's head timestamp is presented to a downstream oldest-first arbiter,
// and the arbiter's grant comes back as rd_vc to pop that head. An empty VC
// presents the all-ones timestamp, so it never wins against an occupied VC.
// Default widths match the TIME_WIDTH / VC_INDEX_WIDTH values used in the
// router's global.vh.
module vc_time_buffer #(
    parameter int DEPTH          = 4,
    parameter int TIME_WIDTH     = 8,
    parameter int VC_INDEX_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [VC_INDEX_WIDTH-1:0] wr_vc,
    input  logic [TIME_WIDTH-1:0]     wr_time,
    input  logic                      rd_en,
    input  logic [VC_INDEX_WIDTH-1:0] rd_vc,
    output logic [TIME_WIDTH-1:0]     time_out_0,
    output logic [TIME_WIDTH-1:0]     time_out_1,
    output logic [TIME_WIDTH-1:0]     time_out_2,
    output logic [TIME_WIDTH-1:0]     time_out_3,
    output logic [TIME_WIDTH-1:0]     time_out_4,
    output logic [4:0]                empty_vec,
    output logic [4:0]                full_vec,
    output logic                      any_valid,
    output logic                      err_ovf,
    output logic                      err_udf
);

    localparam int NUM_VC = 5;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;

    // All-ones means "empty"; a real all-ones timestamp is stored one lower.
    localparam logic [TIME_WIDTH-1:0] TIME_EMPTY = '1;
    localparam logic [TIME_WIDTH-1:0] TIME_CLAMP = {{(TIME_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [PW-1:0]         PTR_ONE    = PW'(1);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL   = CW'(DEPTH);

    logic [TIME_WIDTH-1:0] mem_q    [NUM_VC][DEPTH];
    logic [PW-1:0]         rd_ptr_q [NUM_VC];
    logic [PW-1:0]         rd_ptr_d [NUM_VC];
    logic [PW-1:0]         wr_ptr_q [NUM_VC];
    logic [PW-1:0]         wr_ptr_d [NUM_VC];
    logic [CW-1:0]         count_q  [NUM_VC];
    logic [CW-1:0]         count_d  [NUM_VC];
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_udf_q, err_udf_d;

    logic [NUM_VC-1:0]     wr_hit, rd_hit, wr_ok, rd_ok;
    logic [NUM_VC-1:0]     empty_v, full_v;
    logic [TIME_WIDTH-1:0] wr_data;
    logic [TIME_WIDTH-1:0] head [NUM_VC];

    // Per-VC accept/reject decisions, next pointers/counts, sticky flags and heads.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update, so no latch can be inferred.
        wr_data   = (wr_time == TIME_EMPTY) ? TIME_CLAMP : wr_time;
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        wr_hit    = '0;
        rd_hit    = '0;
        wr_ok     = '0;
        rd_ok     = '0;
        empty_v   = '0;
        full_v    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            rd_ptr_d[i] = rd_ptr_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            count_d[i]  = count_q[i];
            head[i]     = TIME_EMPTY;

            // Out-of-range VC indices never match, so they are silently ignored.
            wr_hit[i]  = wr_en && (wr_vc == VC_INDEX_WIDTH'(i));
            rd_hit[i]  = rd_en && (rd_vc == VC_INDEX_WIDTH'(i));
            empty_v[i] = (count_q[i] == '0);
            full_v[i]  = (count_q[i] == CNT_FULL);

            // A read frees a slot in the same cycle, so a full VC still accepts
            // a same-cycle write; an empty VC never bypasses write to read.
            rd_ok[i] = rd_hit[i] && !empty_v[i];
            wr_ok[i] = wr_hit[i] && (!full_v[i] || rd_ok[i]);

            if (wr_hit[i] && full_v[i] && !rd_ok[i]) err_ovf_d = 1'b1;
            if (rd_hit[i] && empty_v[i])             err_udf_d = 1'b1;

            if (rd_ok[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
            if (wr_ok[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;

            unique case ({wr_ok[i], rd_ok[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_ONE;
                2'b01:   count_d[i] = count_q[i] - CNT_ONE;
                default: count_d[i] = count_q[i];
            endcase

            if (!empty_v[i]) head[i] = mem_q[i][rd_ptr_q[i]];
        end
    end

    // Pointer, occupancy and error-flag registers; reset flushes every FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < NUM_VC; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // Timestamp storage write port.
    // NOTE: storage has no reset; count_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VC; i++) begin
            if (wr_ok[i]) mem_q[i][wr_ptr_q[i]] <= wr_data;
        end
    end

    assign time_out_0 = head[0];
    assign time_out_1 = head[1];
    assign time_out_2 = head[2];
    assign time_out_3 = head[3];
    assign time_out_4 = head[4];
    assign empty_vec  = empty_v;
    assign full_vec   = full_v;
    assign any_valid  = ~&empty_v;
    assign err_ovf    = err_ovf_q;
    assign err_udf    = err_udf_q;

endmodule

// File: tb/tb_vc_time_buffer.sv
// Directed testbench for vc_time_buffer (DEPTH=4, 8-bit timestamps).
// Inputs change 1 ns after the rising edge; outputs are checked at that point.
module tb_vc_time_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_vc;
    logic [7:0] wr_time;
    logic       rd_en;
    logic [2:0] rd_vc;
    logic [7:0] time_out_0, time_out_1, time_out_2, time_out_3, time_out_4;
    logic [4:0] empty_vec, full_vec;
    logic       any_valid, err_ovf, err_udf;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_order [8] = '{8'd1, 8'd2, 8'd4, 8'd6, 8'd8, 8'd9, 8'd12, 8'hFE};
    logic [2:0] arb_vc_tbl [7] = '{3'd3, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd3};
    logic [7:0] arb_ts_tbl [7] = '{8'd1, 8'd2, 8'd4, 8'd6, 8'd8, 8'd9, 8'd12};
    logic [7:0] best;
    logic [2:0] best_vc;

    always #5 clk = ~clk;

    vc_time_buffer #(
        .DEPTH          (4),
        .TIME_WIDTH     (8),
        .VC_INDEX_WIDTH (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_vc      (wr_vc),
        .wr_time    (wr_time),
        .rd_en      (rd_en),
        .rd_vc      (rd_vc),
        .time_out_0 (time_out_0),
        .time_out_1 (time_out_1),
        .time_out_2 (time_out_2),
        .time_out_3 (time_out_3),
        .time_out_4 (time_out_4),
        .empty_vec  (empty_vec),
        .full_vec   (full_vec),
        .any_valid  (any_valid),
        .err_ovf    (err_ovf),
        .err_udf    (err_udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given requests applied, then requests dropped.
    task automatic cycle(input logic we, input logic [2:0] wv, input logic [7:0] wt,
                         input logic re, input logic [2:0] rv);
        wr_en = we; wr_vc = wv; wr_time = wt;
        rd_en = re; rd_vc = rv;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    function automatic logic [7:0] head(input logic [2:0] vc);
        case (vc)
            3'd0:    head = time_out_0;
            3'd1:    head = time_out_1;
            3'd2:    head = time_out_2;
            3'd3:    head = time_out_3;
            default: head = time_out_4;
        endcase
    endfunction

    task automatic check_all_heads_empty(input string tag);
        for (int v = 0; v < 5; v++) check(tag, head(3'(v)), 32'hFF);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_vc = '0; wr_time = '0;
        rd_en = 1'b0; rd_vc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_empty_vec", empty_vec, 5'h1F);
        check("rst_full_vec", full_vec, 5'h00);
        check("rst_any_valid", any_valid, 1'b0);
        check("rst_err_ovf", err_ovf, 1'b0);
        check("rst_err_udf", err_udf, 1'b0);
        check_all_heads_empty("rst_head");

        // Out-of-range VC indices: ignored, no flags
        cycle(1'b1, 3'd5, 8'd9, 1'b1, 3'd6);
        cycle(1'b1, 3'd7, 8'd9, 1'b1, 3'd7);
        check("oor_empty_vec", empty_vec, 5'h1F);
        check("oor_err_ovf", err_ovf, 1'b0);
        check("oor_err_udf", err_udf, 1'b0);

        // VC2: write 7 then 3, pop twice
        cycle(1'b1, 3'd2, 8'd7, 1'b0, 3'd0);
        check("vc2_head_7", time_out_2, 8'd7);
        check("vc2_empty_vec", empty_vec, 5'h1B);
        check("vc2_any_valid", any_valid, 1'b1);
        cycle(1'b1, 3'd2, 8'd3, 1'b0, 3'd0);
        check("vc2_head_still_7", time_out_2, 8'd7);
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd2);
        check("vc2_head_3", time_out_2, 8'd3);
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd2);
        check("vc2_head_drained", time_out_2, 8'hFF);
        check("vc2_empty_bit", empty_vec[2], 1'b1);

        // VC0: fill with 10..13
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 3'd0, 8'(10 + k), 1'b0, 3'd0);
            check("vc0_fill_head", time_out_0, 8'd10);
        end
        check("vc0_full", full_vec, 5'h01);

        // Full VC0: same-cycle write 20 and pop
        cycle(1'b1, 3'd0, 8'd20, 1'b1, 3'd0);
        check("vc0_rw_full", full_vec, 5'h01);
        check("vc0_rw_no_ovf", err_ovf, 1'b0);
        check("vc0_rw_head_11", time_out_0, 8'd11);

        // Full VC0: write 14 dropped
        cycle(1'b1, 3'd0, 8'd14, 1'b0, 3'd0);
        check("vc0_ovf_flag", err_ovf, 1'b1);
        check("vc0_ovf_full", full_vec, 5'h01);
        check("vc0_ovf_head", time_out_0, 8'd11);
        check("vc0_ovf_no_udf", err_udf, 1'b0);

        // Drain: 12, 13, 20, then empty
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        check("vc0_pop_12", time_out_0, 8'd12);
        check("vc0_not_full", full_vec, 5'h00);
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        check("vc0_pop_13", time_out_0, 8'd13);
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        check("vc0_pop_20", time_out_0, 8'd20);
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        check("vc0_drained", time_out_0, 8'hFF);

        // Pointers now sit at 1: refill 30..33 so storage wraps, pop in order
        for (int k = 0; k < 4; k++) cycle(1'b1, 3'd0, 8'(30 + k), 1'b0, 3'd0);
        check("vc0_wrap_full", full_vec, 5'h01);
        for (int k = 0; k < 4; k++) begin
            check("vc0_wrap_head", time_out_0, 32'(30 + k));
            cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd0);
        end
        check("vc0_wrap_drained", time_out_0, 8'hFF);
        check("vc0_wrap_udf_clear", err_udf, 1'b0);

        // Empty VC3: same-cycle write 5 and pop -> read ignored, write kept
        cycle(1'b1, 3'd3, 8'd5, 1'b1, 3'd3);
        check("vc3_udf", err_udf, 1'b1);
        check("vc3_head_5", time_out_3, 8'd5);
        check("vc3_not_empty", empty_vec[3], 1'b0);
        cycle(1'b0, 3'd0, 8'd0, 1'b1, 3'd3);
        check("vc3_drained", time_out_3, 8'hFF);

        // All-ones timestamp is clamped
        cycle(1'b1, 3'd4, 8'hFF, 1'b0, 3'd0);
        check("vc4_clamp", time_out_4, 8'hFE);
        check("vc4_empty_vec", empty_vec, 5'h0F);

        // Load several VCs, then let an oldest-first arbiter model drain them
        for (int k = 0; k < 7; k++) cycle(1'b1, arb_vc_tbl[k], arb_ts_tbl[k], 1'b0, 3'd0);
        check("arb_loaded", empty_vec, 5'h00);
        for (int k = 0; k < 8; k++) begin
            best    = 8'hFF;
            best_vc = 3'd0;
            for (int v = 0; v < 5; v++) begin
                if (head(3'(v)) < best) begin
                    best    = head(3'(v));
                    best_vc = 3'(v);
                end
            end
            check("arb_pop_order", best, exp_order[k]);
            cycle(1'b0, 3'd0, 8'd0, 1'b1, best_vc);
        end
        check("arb_all_empty", empty_vec, 5'h1F);
        check("arb_any_valid", any_valid, 1'b0);

        // Independent read and write on different VCs in one cycle
        cycle(1'b1, 3'd1, 8'd50, 1'b0, 3'd0);
        cycle(1'b1, 3'd2, 8'd51, 1'b1, 3'd1);
        check("diff_vc_head1", time_out_1, 8'hFF);
        check("diff_vc_head2", time_out_2, 8'd51);

        // Asynchronous reset mid-operation flushes immediately
        rst_n = 1'b0;
        #2;
        check("midrst_empty_vec", empty_vec, 5'h1F);
        check("midrst_err_ovf", err_ovf, 1'b0);
        check("midrst_err_udf", err_udf, 1'b0);
        check_all_heads_empty("midrst_head");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 3'd1, 8'd60, 1'b0, 3'd0);
        check("post_rst_write", time_out_1, 8'd60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
